// File: rtl/exec_sched.sv
// Issue scheduler for a 1-cycle add/sub unit with one result slot and an iterative
// mul/div unit. Both units share a single result bus, and the mul/div unit has priority on it.
module exec_sched #(
    parameter int NRS     = 3,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 6
) (
    input  logic           clk1,
    input  logic           rst_n,
    input  logic           flush,
    input  logic [NRS-1:0] add_rdy,
    input  logic [NRS-1:0] mul_rdy,
    input  logic [NRS-1:0] mul_isdiv,
    output logic           add_go,
    output logic [2:0]     add_idx,
    output logic           mul_go,
    output logic [2:0]     mul_idx,
    output logic           mul_div,
    output logic           cdb_valid,
    output logic           cdb_unit,
    output logic [2:0]     cdb_idx,
    output logic           mul_busy,
    output logic           sched_idle
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} mulState_t;

    mulState_t        r_state, w_stateNext;
    logic [CNT_W-1:0] r_cnt, w_cntNext, w_load;
    logic [NRS-1:0]   r_addPend, r_mulPend, w_addPendNext, w_mulPendNext;
    logic [NRS-1:0]   w_addClr, w_addSet, w_mulClr, w_mulSet;
    logic [2:0]       r_addPtr, r_mulPtr, r_unitIdx, r_slotIdx, w_slotIdxNext;
    logic             r_unitDiv, r_slotV, r_armed;
    logic [3:0]       w_addPick, w_mulPick;
    logic             w_pickDiv, w_slotNext, w_addGoNext, w_mulGoNext;
    logic             w_cdbValidNext, w_cdbUnitNext;
    logic [2:0]       w_cdbIdxNext;

    // Returns {found, index}: the first eligible entry at or after ptr, wrapping around.
    function automatic logic [3:0] rrPick(input logic [NRS-1:0] elig, input logic [2:0] ptr);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 0; i < NRS; i++)
            if (!res[3] && elig[i] && (3'(i) >= ptr)) res = {1'b1, 3'(i)};
        for (int i = 0; i < NRS; i++)
            if (!res[3] && elig[i] && (3'(i) < ptr)) res = {1'b1, 3'(i)};
        return res;
    endfunction

    function automatic logic [2:0] nextPtr(input logic [2:0] idx);
        return (idx == 3'(NRS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    always_comb begin
        w_addPick   = rrPick(add_rdy & ~r_addPend, r_addPtr);
        w_mulPick   = rrPick(mul_rdy & ~r_mulPend, r_mulPtr);
        w_pickDiv   = 1'b0;
        w_load      = r_unitDiv ? DIV_LOAD : MUL_LOAD;
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        for (int i = 0; i < NRS; i++)
            if (w_mulPick[2:0] == 3'(i)) w_pickDiv = mul_isdiv[i];

        // The counter reaches 0 as the FSM enters DONE, so a result is on the bus exactly LAT cycles after mul_go.
        case (r_state)
            IDLE: if (mul_go) begin
                w_cntNext   = w_load;
                w_stateNext = (w_load == '0) ? DONE : EXEC;
            end
            EXEC: begin
                w_cntNext = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) w_stateNext = DONE;
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase

        w_slotNext    = add_go | (r_slotV & (r_state == DONE));
        w_slotIdxNext = add_go ? add_idx : r_slotIdx;
        w_addGoNext   = r_armed & w_addPick[3] & ~(w_slotNext & (w_stateNext == DONE));
        w_mulGoNext   = r_armed & w_mulPick[3] & (w_stateNext == IDLE);

        w_addClr = '0;
        w_addSet = '0;
        w_mulClr = '0;
        w_mulSet = '0;
        for (int i = 0; i < NRS; i++) begin
            w_addClr[i] = cdb_valid & ~cdb_unit & (cdb_idx == 3'(i));
            w_mulClr[i] = cdb_valid & cdb_unit & (cdb_idx == 3'(i));
            w_addSet[i] = w_addGoNext & (w_addPick[2:0] == 3'(i));
            w_mulSet[i] = w_mulGoNext & (w_mulPick[2:0] == 3'(i));
        end
        w_addPendNext = (r_addPend & ~w_addClr) | w_addSet;
        w_mulPendNext = (r_mulPend & ~w_mulClr) | w_mulSet;

        if (flush) begin
            w_stateNext   = IDLE;
            w_cntNext     = '0;
            w_slotNext    = 1'b0;
            w_addGoNext   = 1'b0;
            w_mulGoNext   = 1'b0;
            w_addPendNext = '0;
            w_mulPendNext = '0;
        end

        w_cdbUnitNext  = (w_stateNext == DONE);
        w_cdbValidNext = w_cdbUnitNext | w_slotNext;
        w_cdbIdxNext   = w_cdbUnitNext ? r_unitIdx : (w_slotNext ? w_slotIdxNext : 3'd0);
    end

    // r_armed holds off grants until the second edge after reset release.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addPend  <= '0;
            r_mulPend  <= '0;
            r_addPtr   <= 3'd0;
            r_mulPtr   <= 3'd0;
            r_unitIdx  <= 3'd0;
            r_unitDiv  <= 1'b0;
            r_slotV    <= 1'b0;
            r_slotIdx  <= 3'd0;
            r_armed    <= 1'b0;
            add_go     <= 1'b0;
            add_idx    <= 3'd0;
            mul_go     <= 1'b0;
            mul_idx    <= 3'd0;
            mul_div    <= 1'b0;
            cdb_valid  <= 1'b0;
            cdb_unit   <= 1'b0;
            cdb_idx    <= 3'd0;
            mul_busy   <= 1'b0;
            sched_idle <= 1'b1;
        end else begin
            r_armed   <= 1'b1;
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_addPend <= w_addPendNext;
            r_mulPend <= w_mulPendNext;
            r_slotV   <= w_slotNext;
            r_slotIdx <= w_slotIdxNext;
            if (w_addGoNext) r_addPtr <= nextPtr(w_addPick[2:0]);
            if (w_mulGoNext) begin
                r_mulPtr  <= nextPtr(w_mulPick[2:0]);
                r_unitIdx <= w_mulPick[2:0];
                r_unitDiv <= w_pickDiv;
            end
            add_go     <= w_addGoNext;
            add_idx    <= w_addGoNext ? w_addPick[2:0] : 3'd0;
            mul_go     <= w_mulGoNext;
            mul_idx    <= w_mulGoNext ? w_mulPick[2:0] : 3'd0;
            mul_div    <= w_mulGoNext & w_pickDiv;
            cdb_valid  <= w_cdbValidNext;
            cdb_unit   <= w_cdbUnitNext;
            cdb_idx    <= w_cdbIdxNext;
            mul_busy   <= (w_stateNext != IDLE);
            sched_idle <= ~w_addGoNext & ~w_slotNext & (w_stateNext == IDLE) & ~w_mulGoNext;
        end
    end

endmodule

// File: tb/tb_exec_sched.sv
// Directed bench for exec_sched: each step drives inputs after a rising edge
// and checks the registered outputs against hand-computed values.
module tb_exec_sched;

    logic       clk1 = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [2:0] add_rdy, mul_rdy, mul_isdiv;
    logic       add_go, mul_go, mul_div, cdb_valid, cdb_unit, mul_busy, sched_idle;
    logic [2:0] add_idx, mul_idx, cdb_idx;

    int checks = 0;
    int errors = 0;

    logic [2:0] rrGrant [3];
    logic [2:0] rrPrev  [3];

    always #5 clk1 = ~clk1;

    exec_sched #(.NRS(3), .MUL_LAT(3), .DIV_LAT(6)) dut (
        .clk1(clk1), .rst_n(rst_n), .flush(flush),
        .add_rdy(add_rdy), .mul_rdy(mul_rdy), .mul_isdiv(mul_isdiv),
        .add_go(add_go), .add_idx(add_idx), .mul_go(mul_go), .mul_idx(mul_idx),
        .mul_div(mul_div), .cdb_valid(cdb_valid), .cdb_unit(cdb_unit),
        .cdb_idx(cdb_idx), .mul_busy(mul_busy), .sched_idle(sched_idle)
    );

    task automatic applyStimulus(input logic [2:0] aRdy, input logic [2:0] mRdy,
                                 input logic [2:0] mDiv, input logic fl);
        add_rdy   = aRdy;
        mul_rdy   = mRdy;
        mul_isdiv = mDiv;
        flush     = fl;
    endtask

    task automatic stepCycle(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired, observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rrGrant = '{3'd2, 3'd0, 3'd2};
        rrPrev  = '{3'd0, 3'd2, 3'd0};

        // Reset with all add entries ready
        rst_n = 1'b0;
        applyStimulus(3'b111, 3'b000, 3'b000, 1'b0);
        stepCycle(2);
        checkOutput("rstAddGo", add_go, 0);
        checkOutput("rstMulGo", mul_go, 0);
        checkOutput("rstCdbValid", cdb_valid, 0);
        checkOutput("rstMulBusy", mul_busy, 0);
        checkOutput("rstIdle", sched_idle, 1);
        rst_n = 1'b1;
        stepCycle(1);
        checkOutput("firstEdgeNoGrant", add_go, 0);
        stepCycle(1);
        checkOutput("add0Go", add_go, 1);
        checkOutput("add0Idx", add_idx, 0);
        checkOutput("add0CdbValid", cdb_valid, 0);
        checkOutput("add0Idle", sched_idle, 0);
        stepCycle(1);
        checkOutput("add1Go", add_go, 1);
        checkOutput("add1Idx", add_idx, 1);
        checkOutput("cdbAdd0Valid", cdb_valid, 1);
        checkOutput("cdbAdd0Unit", cdb_unit, 0);
        checkOutput("cdbAdd0Idx", cdb_idx, 0);
        stepCycle(1);
        checkOutput("add2Go", add_go, 1);
        checkOutput("add2Idx", add_idx, 2);
        checkOutput("cdbAdd1Idx", cdb_idx, 1);
        applyStimulus(3'b000, 3'b000, 3'b000, 1'b0);
        stepCycle(1);
        checkOutput("addStopGo", add_go, 0);
        checkOutput("cdbAdd2Valid", cdb_valid, 1);
        checkOutput("cdbAdd2Idx", cdb_idx, 2);
        stepCycle(1);
        checkOutput("addDoneCdbValid", cdb_valid, 0);
        checkOutput("addDoneCdbIdx", cdb_idx, 0);
        checkOutput("addDoneCdbUnit", cdb_unit, 0);
        checkOutput("addDoneIdle", sched_idle, 1);

        // Multiply latency; the RS entry clears after issue but the result still broadcasts
        applyStimulus(3'b000, 3'b010, 3'b000, 1'b0);
        stepCycle(1);
        checkOutput("mulGo", mul_go, 1);
        checkOutput("mulIdx", mul_idx, 1);
        checkOutput("mulDiv", mul_div, 0);
        checkOutput("mulBusyAtGo", mul_busy, 0);
        applyStimulus(3'b000, 3'b000, 3'b000, 1'b0);
        stepCycle(1);
        checkOutput("mulC1Busy", mul_busy, 1);
        checkOutput("mulC1Go", mul_go, 0);
        checkOutput("mulC1Cdb", cdb_valid, 0);
        stepCycle(1);
        checkOutput("mulC2Busy", mul_busy, 1);
        checkOutput("mulC2Cdb", cdb_valid, 0);
        stepCycle(1);
        checkOutput("mulC3Cdb", cdb_valid, 1);
        checkOutput("mulC3Unit", cdb_unit, 1);
        checkOutput("mulC3Idx", cdb_idx, 1);
        checkOutput("mulC3Busy", mul_busy, 1);
        stepCycle(1);
        checkOutput("mulC4Busy", mul_busy, 0);
        checkOutput("mulC4Cdb", cdb_valid, 0);
        checkOutput("mulC4Idle", sched_idle, 1);

        // Divide latency with a second mul entry waiting
        applyStimulus(3'b000, 3'b101, 3'b100, 1'b0);
        stepCycle(1);
        checkOutput("divGo", mul_go, 1);
        checkOutput("divIdx", mul_idx, 2);
        checkOutput("divDiv", mul_div, 1);
        for (int k = 1; k <= 5; k++) begin
            stepCycle(1);
            checkOutput("divWaitGo", mul_go, 0);
            checkOutput("divWaitCdb", cdb_valid, 0);
        end
        stepCycle(1);
        checkOutput("divCdbValid", cdb_valid, 1);
        checkOutput("divCdbUnit", cdb_unit, 1);
        checkOutput("divCdbIdx", cdb_idx, 2);
        checkOutput("divNoEarlyGo", mul_go, 0);
        stepCycle(1);
        checkOutput("secondMulGo", mul_go, 1);
        checkOutput("secondMulIdx", mul_idx, 0);
        checkOutput("secondMulDiv", mul_div, 0);
        checkOutput("secondMulCdb", cdb_valid, 0);
        applyStimulus(3'b000, 3'b000, 3'b000, 1'b0);

        // CDB collision: add issued so its result lands when the mul finishes
        stepCycle(1);
        applyStimulus(3'b001, 3'b000, 3'b000, 1'b0);
        stepCycle(1);
        checkOutput("colAddGo", add_go, 1);
        checkOutput("colAddIdx", add_idx, 0);
        applyStimulus(3'b011, 3'b000, 3'b000, 1'b0);
        stepCycle(1);
        checkOutput("colNoAddGo", add_go, 0);
        checkOutput("colMulCdbValid", cdb_valid, 1);
        checkOutput("colMulCdbUnit", cdb_unit, 1);
        checkOutput("colMulCdbIdx", cdb_idx, 0);
        stepCycle(1);
        checkOutput("colAddResumeGo", add_go, 1);
        checkOutput("colAddResumeIdx", add_idx, 1);
        checkOutput("colAddCdbValid", cdb_valid, 1);
        checkOutput("colAddCdbUnit", cdb_unit, 0);
        checkOutput("colAddCdbIdx", cdb_idx, 0);
        applyStimulus(3'b000, 3'b000, 3'b000, 1'b0);
        stepCycle(1);
        checkOutput("colAdd1CdbUnit", cdb_unit, 0);
        checkOutput("colAdd1CdbIdx", cdb_idx, 1);
        checkOutput("colAdd1NoGo", add_go, 0);
        stepCycle(1);
        checkOutput("colDoneCdb", cdb_valid, 0);
        checkOutput("colDoneIdle", sched_idle, 1);

        // Round-robin from a fresh reset with entries 0 and 2 held ready
        rst_n = 1'b0;
        applyStimulus(3'b000, 3'b101, 3'b000, 1'b0);
        stepCycle(1);
        rst_n = 1'b1;
        stepCycle(1);
        checkOutput("rrFirstEdgeNoGo", mul_go, 0);
        stepCycle(1);
        checkOutput("rrGo0", mul_go, 1);
        checkOutput("rrIdx0", mul_idx, 0);
        for (int k = 0; k < 3; k++) begin
            stepCycle(3);
            checkOutput("rrBusyNoGo", mul_go, 0);
            checkOutput("rrCdbIdx", cdb_idx, rrPrev[k]);
            stepCycle(1);
            checkOutput("rrGo", mul_go, 1);
            checkOutput("rrIdx", mul_idx, rrGrant[k]);
        end

        // Reset asserted mid-multiply discards the operation
        stepCycle(1);
        checkOutput("midOpBusy", mul_busy, 1);
        rst_n = 1'b0;
        applyStimulus(3'b000, 3'b100, 3'b100, 1'b0);
        #1;
        checkOutput("midRstBusy", mul_busy, 0);
        checkOutput("midRstCdb", cdb_valid, 0);
        checkOutput("midRstIdle", sched_idle, 1);
        stepCycle(1);
        rst_n = 1'b1;
        stepCycle(1);
        checkOutput("midRstNoCdb", cdb_valid, 0);
        checkOutput("midRstNoGo", mul_go, 0);

        // Flush two cycles after a divide issues
        stepCycle(1);
        checkOutput("flDivGo", mul_go, 1);
        checkOutput("flDivIdx", mul_idx, 2);
        checkOutput("flDivDiv", mul_div, 1);
        applyStimulus(3'b000, 3'b000, 3'b000, 1'b0);
        stepCycle(2);
        checkOutput("flPreBusy", mul_busy, 1);
        applyStimulus(3'b000, 3'b000, 3'b000, 1'b1);
        stepCycle(1);
        checkOutput("flBusy", mul_busy, 0);
        checkOutput("flCdb", cdb_valid, 0);
        checkOutput("flIdle", sched_idle, 1);
        checkOutput("flGo", mul_go, 0);
        applyStimulus(3'b000, 3'b010, 3'b000, 1'b0);
        stepCycle(1);
        checkOutput("flNewGo", mul_go, 1);
        checkOutput("flNewIdx", mul_idx, 1);
        checkOutput("flNewCdb", cdb_valid, 0);
        applyStimulus(3'b000, 3'b000, 3'b000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            stepCycle(1);
            checkOutput("flNoStaleCdb", cdb_valid, 0);
        end
        stepCycle(1);
        checkOutput("flNewCdbValid", cdb_valid, 1);
        checkOutput("flNewCdbUnit", cdb_unit, 1);
        checkOutput("flNewCdbIdx", cdb_idx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
